// File: rtl/mem_arb_types.sv
// Shared types and width defaults for the memory port arbiter.
package mem_arb_types;
  localparam int ADDR_W_DEF      = 64;
  localparam int DATA_W_DEF      = 64;
  localparam int MEM_LATENCY_DEF = 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating priority; otherwise data always wins.
module arb_pick
  import mem_arb_types::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_e last_owner,
`endif
  output logic   any_req,
  output owner_e winner
);

  always_comb begin
    any_req = i_req | d_req;
    winner  = OWN_INSTR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      winner = (last_owner == OWN_DATA) ? OWN_INSTR : OWN_DATA;
    end else if (d_req) begin
      winner = OWN_DATA;
    end
`else
    if (d_req) begin
      winner = OWN_DATA;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto one single-port memory.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (round-robin instead of data priority).
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              busy_q, busy_d;
  logic              any_req;
  owner_e            winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e            last_q, last_d;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_q),
    .any_req    (any_req),
    .winner     (winner)
  );
`else
  arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .any_req (any_req),
    .winner  (winner)
  );
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_be_d   = '0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ACCESS;
          owner_d  = winner;
          mem_en_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d   = winner;
`endif
          // Instruction accesses are always reads with no byte lanes.
          if (winner == OWN_DATA) begin
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            mem_we_d = d_we;
            mem_be_d = d_be;
            d_gnt_d  = 1'b1;
          end else begin
            addr_d   = i_addr;
            wdata_d  = '0;
            i_gnt_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = mem_rdata;
            i_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_INSTR;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      mem_be_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= OWN_INSTR;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_be_q   <= mem_be_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      busy_q     <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push cycle-stamped
// expectations, a negedge monitor pops them as the DUT raises mem_en/gnt/rvalid.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int cyc; logic [AW-1:0] a; logic we; logic [BW-1:0] be; logic [DW-1:0] wd;} mem_exp_t;
  typedef struct {int cyc; logic own;} gnt_exp_t;
  typedef struct {int cyc; logic [DW-1:0] d;} rv_exp_t;

  mem_exp_t mem_q[$];
  gnt_exp_t gnt_q[$];
  rv_exp_t  ri_q[$];
  rv_exp_t  rd_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (a == 64'h40) return 64'h00A0_0093;
    return {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
  endfunction

  // Memory model: data for a read strobed in cycle k is present only in cycle k+LAT.
  int            due = -1;
  logic [DW-1:0] due_d = '0;
  always @(negedge clk) begin
    if (mem_en && !mem_we) begin
      due   = cyc + LAT;
      due_d = mem_val(mem_addr);
    end
    mem_rdata = (cyc == due) ? due_d : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  always @(negedge clk) begin : monitor
    mem_exp_t me;
    gnt_exp_t ge;
    rv_exp_t  re;
    if (!reset) begin
      if (mem_en) begin
        if (mem_q.size() == 0) flag("mem_en_extra");
        else begin
          me = mem_q.pop_front();
          chk("mem_cyc", 64'(cyc), 64'(me.cyc));
          chk("mem_addr", mem_addr, me.a);
          chk("mem_we", 64'(mem_we), 64'(me.we));
          chk("mem_be", 64'(mem_be), 64'(me.be));
          if (me.we) chk("mem_wdata", mem_wdata, me.wd);
        end
      end
      if (i_gnt && d_gnt) flag("gnt_both");
      if (i_gnt || d_gnt) begin
        if (gnt_q.size() == 0) flag("gnt_extra");
        else begin
          ge = gnt_q.pop_front();
          chk("gnt_cyc", 64'(cyc), 64'(ge.cyc));
          chk("gnt_owner_d", 64'(d_gnt), 64'(ge.own));
        end
      end
      if (i_rvalid) begin
        if (ri_q.size() == 0) flag("i_rvalid_extra");
        else begin
          re = ri_q.pop_front();
          chk("i_rvalid_cyc", 64'(cyc), 64'(re.cyc));
          chk("i_rdata", i_rdata, re.d);
        end
      end
      if (d_rvalid) begin
        if (rd_q.size() == 0) flag("d_rvalid_extra");
        else begin
          re = rd_q.pop_front();
          chk("d_rvalid_cyc", 64'(cyc), 64'(re.cyc));
          chk("d_rdata", d_rdata, re.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) flag("idle_timeout");
    tick();
  endtask

  // Expectations for one transaction sampled in IDLE at cycle s.
  task automatic expect_tr(input int s, input logic own, input logic [AW-1:0] a,
                           input logic we, input logic [BW-1:0] be, input logic [DW-1:0] wd);
    mem_q.push_back('{cyc: s + 1, a: a, we: we, be: be, wd: wd});
    gnt_q.push_back('{cyc: s + 1, own: own});
    if (!we) begin
      if (own) rd_q.push_back('{cyc: s + 2 + LAT, d: mem_val(a)});
      else     ri_q.push_back('{cyc: s + 2 + LAT, d: mem_val(a)});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_gnt"}, 64'({i_gnt, d_gnt}), 0);
    chk({tag, "_rvalid"}, 64'({i_rvalid, d_rvalid}), 0);
    chk({tag, "_mem_en_we"}, 64'({mem_en, mem_we}), 0);
    chk({tag, "_mem_be"}, 64'(mem_be), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic single(input logic own, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be);
    int c = cyc;
    if (own) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    expect_tr(c, own, a, own & we, own ? be : '0, wd);
    tick();
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    if (we) chk("store_busy_n2", 64'(busy), 0);
    wait_idle();
  endtask

  task automatic held(input int n_tr);
    int  c = cyc;
    logic own;
    i_req = 1'b1; i_addr = 64'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; d_be = 8'hFF;
    for (int k = 0; k < n_tr; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      own = ((k % 2) == 0);
`else
      own = 1'b1;
`endif
      expect_tr(c + k * (LAT + 3), own, own ? 64'h300 : 64'h80, 1'b0, own ? 8'hFF : 8'h00, '0);
    end
    repeat ((n_tr - 1) * (LAT + 3) + 2) tick();
    i_req = 1'b0;
    d_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    single(1'b0, 1'b0, 64'h40, '0, '0);
    single(1'b1, 1'b1, 64'h100, 64'hFF, 8'h01);
    single(1'b1, 1'b0, 64'h208, '0, 8'hFF);

    // Back-to-back loads: d_req stays high with a new address after the first grant.
    c = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400; d_be = 8'hFF;
    expect_tr(c, 1'b1, 64'h400, 1'b0, 8'hFF, '0);
    expect_tr(c + LAT + 3, 1'b1, 64'h410, 1'b0, 8'hFF, '0);
    tick();
    tick();
    d_addr = 64'h410;
    repeat (LAT + 3) tick();
    d_req = 1'b0;
    wait_idle();

    held(4);

    // Reset while the load sits in WAIT: transaction is abandoned.
    c = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500; d_be = 8'hFF;
    mem_q.push_back('{cyc: c + 1, a: 64'h500, we: 1'b0, be: 8'hFF, wd: '0});
    gnt_q.push_back('{cyc: c + 1, own: 1'b1});
    tick();
    tick();
    d_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("mid_reset");
    repeat (10) tick();

    chk("mem_q_empty", 64'(mem_q.size()), 0);
    chk("gnt_q_empty", 64'(gnt_q.size()), 0);
    chk("ri_q_empty", 64'(ri_q.size()), 0);
    chk("rd_q_empty", 64'(rd_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory between the instruction-fetch requester and the data load/store requester of the multicycle core. Both requesters issue commands through a req/gnt handshake. Reads are returned through a registered rvalid/rdata pair after a fixed memory latency. The control FSM keeps its existing sequencing; this block serialises the accesses and owns the memory-side strobes.

## Interface
- ADDR_W, 64, address width (byte address)
- DATA_W, 64, data width; byte-enable width is DATA_W/8
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal values are 1 or more
- clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request accepted
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data, already positioned by the store splice
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  out  DATA_W  loaded word
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  1 whenever the FSM is not in IDLE

## Operation
- FSM states and transitions:
  - IDLE: samples requests. If any request is present, go to ACCESS.
  - ACCESS: go to IDLE for a write, otherwise to WAIT.
  - WAIT: go to RESP once the counter reaches 0.
  - RESP: go to IDLE.
- Requests are sampled only in IDLE. At the IDLE edge the winner's addr/we/wdata/be and its owner ID are captured into registers.
- In ACCESS:
  - mem_en=1, and mem_we, mem_addr, mem_wdata, mem_be come from the captured registers.
  - The winner's gnt=1.
  - mem_we and mem_be are forced to 0 for instruction accesses.
- WAIT:
  - A down-counter is loaded with MEM_LATENCY-1 on entry and decremented each WAIT cycle.
  - mem_rdata is captured into the owner's rdata register on the edge that leaves WAIT.
- RESP: the owner's rvalid=1. The rdata registers hold their value until the next capture.
- Arbitration: when both requesters are present in IDLE, data wins (fixed priority). A lone requester always wins.
- Requester rules:
  - Hold req and its payload stable from assertion until gnt.
  - Deassert req in the cycle after gnt, unless a new request is being presented.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Stores complete at the ACCESS cycle and produce no rvalid.
- Reset values:
  - State is IDLE; the counter, captured registers and both rdata registers are all 0.
  - All gnt, rvalid, mem_en, mem_we and busy outputs are 0; mem_be is 0.
  - Reset in mid-transaction abandons the transaction with no rvalid, and asserts no mem_en in the following cycle.

## Timing
- Read sampled in IDLE at cycle N:
  - mem_en and gnt at N+1.
  - mem_rdata valid at N+1+MEM_LATENCY.
  - rvalid at N+2+MEM_LATENCY.
  - IDLE again at N+3+MEM_LATENCY.
- Write sampled at N: mem_en, mem_we and gnt at N+1; IDLE at N+2. Earliest next mem_en is N+3.
- Outputs derive only from registered state; there is no combinational path from req to gnt or mem_*.
- Throughput: at most one transaction in flight.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: a last_owner register (reset value = instruction) is updated on each grant. When both requesters are present, the one not granted last wins.
  - Undefined: fixed data priority, and the last_owner register is absent.

## Structure
- Shared package mem_arb_types holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP);
  - the owner enum (OWN_INSTR, OWN_DATA);
  - the width constants' defaults.
- One sub-module, arb_pick: combinational winner selection from i_req, d_req and last_owner. It contains the MEM_ARB_ROUND_ROBIN_EN logic. The FSM, counter and registers stay in mem_port_arbiter.

## Test plan
- Lone fetch, MEM_LATENCY=2, i_addr=0x40, mem_rdata=0x00A00093 at its valid cycle:
  - i_gnt at N+1; i_rvalid with i_rdata=0x00A00093 at N+4.
  - d_gnt and d_rvalid stay 0.
- Store, d_addr=0x100, d_wdata=0xFF, d_be=0x01:
  - mem_en=1, mem_we=1, mem_be=0x01 for exactly one cycle at N+1.
  - No d_rvalid; busy=0 at N+2.
- i_req and d_req held continuously, with MEM_LATENCY=1 and MEM_ARB_ROUND_ROBIN_EN undefined:
  - every grant goes to data; i_gnt never asserts.
  - With the macro defined, grants alternate D, I, D, I.
- Load in flight, reset asserted during WAIT for one cycle:
  - next cycle state is IDLE and all outputs are 0.
  - No d_rvalid is ever produced for the abandoned load.
- Back-to-back loads with d_req held high after d_gnt:
  - second mem_en occurs exactly MEM_LATENCY+3 cycles after the first.
  - Each d_rvalid carries its own mem_rdata.
